// File: rtl/load_store_unit_if.sv
// Bus bundle between the MEM pipeline stage, the load/store unit and the
// data memory.
//   req_*  : pipeline -> LSU request channel (valid/ready handshake)
//   resp_* : LSU -> pipeline one-cycle completion, plus busy stall source
//   mem_*  : LSU <-> data memory memread/memwrite/clk_stall protocol
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (pipeline + memory) around it
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_stall,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output mem_addr, mem_wdata, mem_read, mem_write, mem_mask
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_stall,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_mask
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for the data memory's
// memread/memwrite/clk_stall protocol. Takes one load/store at a time,
// encodes RV32I funct3 into the memory sign_mask, pulses the strobe for one
// cycle, waits for the memory stall to rise and fall, then returns a
// one-cycle response (with error flag for misaligned/illegal/timeout).
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : load_store_unit_if.slave (request, response and memory signals)
// Parameters:
//   TIMEOUT_CYCLES : WAIT-state cycles before abort
// Optional feature macro: LSU_TIMEOUT_EN (WAIT-state timeout counter).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        stall_seen_q, stall_seen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        busy_q, busy_d;

  logic [3:0]  req_mask;
  logic        req_ok;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT_CYCLES has no effect without the timeout counter.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
  end
`endif

  // {signed, size}; 0000 marks an illegal funct3 since every legal mask is non-zero.
  function automatic logic [3:0] mask_of(input logic wr, input logic [2:0] f3);
    logic [3:0] m;
    m = 4'b0000;
    if (!wr) begin
      case (f3)
        3'b000:  m = 4'b1001;
        3'b001:  m = 4'b1011;
        3'b010:  m = 4'b0111;
        3'b100:  m = 4'b0001;
        3'b101:  m = 4'b0011;
        default: m = 4'b0000;
      endcase
    end else begin
      case (f3)
        3'b000:  m = 4'b0001;
        3'b001:  m = 4'b0011;
        3'b010:  m = 4'b0111;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      3'b011:  ok = (a[0] == 1'b0);
      3'b111:  ok = (a == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign req_mask = mask_of(bus.req_write, bus.req_funct3);
  assign req_ok   = (req_mask != 4'b0000) && is_aligned(req_mask[2:0], bus.req_addr[1:0]);

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    stall_seen_d = stall_seen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = mem_mask_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    busy_d       = busy_q;
`ifdef LSU_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          busy_d = 1'b1;
          if (!req_ok) begin
            // Rejected without touching memory.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else begin
            write_d     = bus.req_write;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
            mem_mask_d  = req_mask;
            mem_read_d  = !bus.req_write;
            mem_write_d = bus.req_write;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Strobe is visible during this cycle; it drops at the next edge so
        // the memory does not re-issue once it returns to idle.
        stall_seen_d = 1'b0;
        state_d      = WAIT;
`ifdef LSU_TIMEOUT_EN
        tmo_d        = '0;
`endif
      end
      WAIT: begin
        if (stall_seen_q && !bus.mem_stall) begin
          if (!write_q) resp_rdata_d = bus.mem_rdata;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          if (bus.mem_stall) stall_seen_d = 1'b1;
`ifdef LSU_TIMEOUT_EN
          if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      stall_seen_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mask_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      stall_seen_q <= stall_seen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      busy_q       <= busy_d;
`ifdef LSU_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.busy       = busy_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_mask   = mem_mask_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;

endmodule
